// File: rtl/stage4_mem_pkg.sv
// stage4_mem_pkg: shared encodings for the memory-access stage.
`default_nettype none

package stage4_mem_pkg;

  // RV32I load/store func3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stage4_mem_load_store_align.sv
// load_store_align: byte-lane steering for stores and lane extract/extend for loads.
`default_nettype none

module load_store_align
  import stage4_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic        is_store,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bad_func3
);

  logic [31:0] lane;

  always_comb begin
    lane      = rdata >> {addr_lo, 3'b000};
    be        = BE_WORD;
    wdata     = reg2;
    load_data = lane;
    bad_func3 = 1'b0;
    case (func3)
      F3_B: begin
        be        = BE_BYTE << addr_lo;
        wdata     = {4{reg2[7:0]}};
        load_data = {{24{lane[7]}}, lane[7:0]};
      end
      F3_H: begin
        be        = BE_HALF << {addr_lo[1], 1'b0};
        wdata     = {2{reg2[15:0]}};
        load_data = {{16{lane[15]}}, lane[15:0]};
      end
      F3_W: begin
        be        = BE_WORD;
        wdata     = reg2;
        load_data = rdata;
      end
      F3_BU: begin
        be        = BE_BYTE << addr_lo;
        load_data = {24'h0, lane[7:0]};
      end
      F3_HU: begin
        be        = BE_HALF << {addr_lo[1], 1'b0};
        load_data = {16'h0, lane[15:0]};
      end
      default: bad_func3 = 1'b1;
    endcase
    // Unsigned variants only exist for loads
    if (is_store && func3[2]) bad_func3 = 1'b1;
    misalign = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
               ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
  end

endmodule

`default_nettype wire

// File: rtl/stage4_mem.sv
// stage4_mem: RISC-V MEM stage - req/ack data-memory access, stall control, MEM/WB register.
`default_nettype none

module stage4_mem
  import stage4_mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exmemValid,
  input  logic [XLEN-1:0] exmemAlu,
  input  logic [XLEN-1:0] exmemReg2,
  input  logic [4:0]      exmemRd,
  input  logic [2:0]      exmemFunc3,
  input  logic            exmemMemRead,
  input  logic            exmemMemWrite,
  input  logic            exmemMemToReg,
  input  logic            exmemWb,
  output logic            dmemReq,
  output logic            dmemWe,
  output logic [XLEN-1:0] dmemAddr,
  output logic [XLEN-1:0] dmemWdata,
  output logic [3:0]      dmemBe,
  input  logic            dmemAck,
  input  logic [XLEN-1:0] dmemRdata,
  output logic            memStall,
  output logic            memwbValid,
  output logic            memwbWb,
  output logic            memwbMemToReg,
  output logic [4:0]      memwbRd,
  output logic [XLEN-1:0] memwbAlu,
  output logic [XLEN-1:0] memwbMemData,
  output logic            memFault
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              mem_op, is_store, misalign, bad_func3, access_ok, op_fault;
  logic              at_limit, req, stall, complete, timeout;
  logic [XLEN-1:0]   load_data;

  load_store_align u_align (
    .addr_lo   (exmemAlu[1:0]),
    .func3     (exmemFunc3),
    .is_store  (is_store),
    .reg2      (exmemReg2),
    .rdata     (dmemRdata),
    .be        (dmemBe),
    .wdata     (dmemWdata),
    .load_data (load_data),
    .misalign  (misalign),
    .bad_func3 (bad_func3)
  );

  assign mem_op    = exmemValid & (exmemMemRead | exmemMemWrite);
  assign is_store  = exmemMemWrite;
  assign access_ok = mem_op & ~misalign & ~bad_func3;
  assign op_fault  = mem_op & (misalign | bad_func3);
  assign at_limit  = (cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign dmemWe    = is_store;
  assign dmemAddr  = {exmemAlu[XLEN-1:2], 2'b00};

  // Request and stall are forced low while reset is asserted, independent of the clock
  assign dmemReq  = req & rst_n;
  assign memStall = stall & rst_n;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (access_ok) begin
          req = 1'b1;
          if (dmemAck) begin
            complete = 1'b1;
          end else begin
            stall     = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Request is withdrawn in the last allowed cycle; a late ack still completes
        req = ~at_limit;
        if (dmemAck) begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end else if (at_limit) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwbValid    <= 1'b0;
      memwbWb       <= 1'b0;
      memwbMemToReg <= 1'b0;
      memwbRd       <= '0;
      memwbAlu      <= '0;
      memwbMemData  <= '0;
      memFault      <= 1'b0;
    end else begin
      memFault <= timeout | ((state == S_IDLE) & op_fault);
      if (complete) begin
        memwbValid    <= 1'b1;
        memwbWb       <= exmemWb & ~is_store;
        memwbMemToReg <= exmemMemToReg;
        memwbRd       <= exmemRd;
        memwbAlu      <= exmemAlu;
        memwbMemData  <= is_store ? '0 : load_data;
      end else if ((state == S_IDLE) && exmemValid && !mem_op) begin
        memwbValid    <= 1'b1;
        memwbWb       <= exmemWb;
        memwbMemToReg <= 1'b0;
        memwbRd       <= exmemRd;
        memwbAlu      <= exmemAlu;
        memwbMemData  <= '0;
      end else begin
        // Bubble so forwarding never picks up a stale MEM/WB entry
        memwbValid <= 1'b0;
        memwbWb    <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage4_mem.sv
// tb_stage4_mem: directed vectors for the MEM stage with hand-computed expectations.
`default_nettype none

module tb_stage4_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exmemValid, exmemMemRead, exmemMemWrite, exmemMemToReg, exmemWb;
  logic [31:0] exmemAlu, exmemReg2;
  logic [4:0]  exmemRd;
  logic [2:0]  exmemFunc3;
  logic        dmemReq, dmemWe, dmemAck;
  logic [31:0] dmemAddr, dmemWdata, dmemRdata;
  logic [3:0]  dmemBe;
  logic        memStall, memwbValid, memwbWb, memwbMemToReg, memFault;
  logic [4:0]  memwbRd;
  logic [31:0] memwbAlu, memwbMemData;

  int total = 0;
  int bad   = 0;

  stage4_mem #(.XLEN(32), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .exmemValid(exmemValid), .exmemAlu(exmemAlu), .exmemReg2(exmemReg2),
    .exmemRd(exmemRd), .exmemFunc3(exmemFunc3), .exmemMemRead(exmemMemRead),
    .exmemMemWrite(exmemMemWrite), .exmemMemToReg(exmemMemToReg), .exmemWb(exmemWb),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemBe(dmemBe), .dmemAck(dmemAck), .dmemRdata(dmemRdata),
    .memStall(memStall), .memwbValid(memwbValid), .memwbWb(memwbWb),
    .memwbMemToReg(memwbMemToReg), .memwbRd(memwbRd), .memwbAlu(memwbAlu),
    .memwbMemData(memwbMemData), .memFault(memFault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic [31:0] alu, input logic [31:0] r2,
                        input logic [4:0] rd, input logic [2:0] f3,
                        input logic rd_en, input logic wr_en);
    exmemValid    = v;
    exmemAlu      = alu;
    exmemReg2     = r2;
    exmemRd       = rd;
    exmemFunc3    = f3;
    exmemMemRead  = rd_en;
    exmemMemWrite = wr_en;
    exmemMemToReg = rd_en & ~wr_en;
    exmemWb       = 1'b1;
  endtask

  task automatic clear_op();
    set_op(1'b0, 32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0);
    dmemAck = 1'b0;
  endtask

  // Called at a negedge; ack arrives after `waits` stall cycles
  task automatic run_access(input string tag, input logic [31:0] alu, input logic [31:0] r2,
                            input logic [2:0] f3, input logic wr, input int waits,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_data);
    int stalls = 0;
    set_op(1'b1, alu, r2, 5'd9, f3, ~wr, wr);
    dmemRdata = rdata;
    dmemAck   = 1'b0;
    #1;
    chk({tag, ".req"}, {31'd0, dmemReq}, 32'd1);
    chk({tag, ".we"}, {31'd0, dmemWe}, {31'd0, wr});
    chk({tag, ".addr"}, dmemAddr, {alu[31:2], 2'b00});
    chk({tag, ".be"}, {28'd0, dmemBe}, {28'd0, exp_be});
    if (wr) chk({tag, ".wdata"}, dmemWdata, exp_wdata);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) dmemAck = 1'b1;
      #1;
      if (memStall) stalls++;
      @(posedge clk);
      #1;
      if (i < waits) chk({tag, ".bubble"}, {31'd0, memwbValid}, 32'd0);
      @(negedge clk);
    end
    chk({tag, ".stalls"}, stalls, waits);
    chk({tag, ".valid"}, {31'd0, memwbValid}, 32'd1);
    chk({tag, ".wb"}, {31'd0, memwbWb}, {31'd0, ~wr});
    chk({tag, ".data"}, memwbMemData, exp_data);
    chk({tag, ".rd"}, {27'd0, memwbRd}, 32'd9);
    clear_op();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    bit done;
    rst_n = 1'b0;
    dmemRdata = 32'h0;
    clear_op();
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, memwbValid}, 32'd0);
    chk("rst.fault", {31'd0, memFault}, 32'd0);
    chk("rst.req", {31'd0, dmemReq}, 32'd0);
    chk("rst.stall", {31'd0, memStall}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_access("lw0",  32'h100, 32'h0, 3'b010, 1'b0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    chk("lw0.m2r", {31'd0, memwbMemToReg}, 32'd1);
    run_access("lb3",  32'h103, 32'h0, 3'b000, 1'b0, 3, 32'h80FF0000, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_access("lbu3", 32'h103, 32'h0, 3'b100, 1'b0, 3, 32'h80FF0000, 4'b1000, 32'h0, 32'h00000080);
    run_access("lh2",  32'h102, 32'h0, 3'b001, 1'b0, 1, 32'h80017777, 4'b1100, 32'h0, 32'hFFFF8001);
    run_access("lhu2", 32'h102, 32'h0, 3'b101, 1'b0, 0, 32'h80017777, 4'b1100, 32'h0, 32'h00008001);
    run_access("sh",   32'h202, 32'h1234ABCD, 3'b001, 1'b1, 1, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    run_access("sb",   32'h201, 32'h00000077, 3'b000, 1'b1, 0, 32'h0, 4'b0010, 32'h77777777, 32'h0);

    // Non-memory passthrough
    set_op(1'b1, 32'h55, 32'h0, 5'd7, 3'b000, 1'b0, 1'b0);
    #1;
    chk("alu.req", {31'd0, dmemReq}, 32'd0);
    @(posedge clk); #1;
    chk("alu.valid", {31'd0, memwbValid}, 32'd1);
    chk("alu.wb", {31'd0, memwbWb}, 32'd1);
    chk("alu.res", memwbAlu, 32'h55);
    chk("alu.data", memwbMemData, 32'h0);
    chk("alu.m2r", {31'd0, memwbMemToReg}, 32'd0);
    @(negedge clk);

    // Misaligned word load
    set_op(1'b1, 32'h101, 32'h0, 5'd3, 3'b010, 1'b1, 1'b0);
    #1;
    chk("mis.req", {31'd0, dmemReq}, 32'd0);
    chk("mis.stall", {31'd0, memStall}, 32'd0);
    @(posedge clk); #1;
    chk("mis.fault", {31'd0, memFault}, 32'd1);
    chk("mis.valid", {31'd0, memwbValid}, 32'd0);
    @(negedge clk);
    clear_op();
    @(posedge clk); #1;
    chk("mis.pulse", {31'd0, memFault}, 32'd0);
    @(negedge clk);

    // Illegal store width
    set_op(1'b1, 32'h200, 32'h0, 5'd0, 3'b011, 1'b0, 1'b1);
    #1;
    chk("ill.req", {31'd0, dmemReq}, 32'd0);
    @(posedge clk); #1;
    chk("ill.fault", {31'd0, memFault}, 32'd1);
    @(negedge clk);
    clear_op();

    // Timeout: ack never arrives
    set_op(1'b1, 32'h200, 32'h0, 5'd4, 3'b010, 1'b1, 1'b0);
    stalls = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (memStall) begin
        stalls++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    chk("to.stalls", stalls, 16);
    chk("to.req", {31'd0, dmemReq}, 32'd0);
    @(posedge clk); #1;
    chk("to.fault", {31'd0, memFault}, 32'd1);
    chk("to.valid", {31'd0, memwbValid}, 32'd0);
    @(negedge clk);
    run_access("to.next", 32'h104, 32'h0, 3'b010, 1'b0, 0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);
    chk("to.fault_clr", {31'd0, memFault}, 32'd0);

    // Reset in the middle of a WAIT
    set_op(1'b1, 32'h300, 32'h0, 5'd5, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk); #1;
    chk("rw.stall_pre", {31'd0, memStall}, 32'd1);
    chk("rw.req_pre", {31'd0, dmemReq}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw.req", {31'd0, dmemReq}, 32'd0);
    chk("rw.stall", {31'd0, memStall}, 32'd0);
    chk("rw.valid", {31'd0, memwbValid}, 32'd0);
    chk("rw.alu", memwbAlu, 32'h0);
    chk("rw.data", memwbMemData, 32'h0);
    chk("rw.rd", {27'd0, memwbRd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Same op still presented: an IDLE FSM issues it with no stall when ack is immediate
    dmemAck = 1'b1;
    dmemRdata = 32'h13579BDF;
    #1;
    chk("rw.idle_stall", {31'd0, memStall}, 32'd0);
    chk("rw.idle_req", {31'd0, dmemReq}, 32'd1);
    @(posedge clk); #1;
    chk("rw.after", memwbMemData, 32'h13579BDF);
    @(negedge clk);
    clear_op();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
